hazard_forward_ctrl: RTL and testbench

Parametrised hazard-detection and forwarding controller for the pipelined ARM datapath. It sits beside the ID stage and sees the ID source registers and the destination/control fields of every downstream pipeline stage. It drives the operand forwarding-mux selects, the PC and IF/ID enables, NOP insertion into ID/EX, and the IF/ID flush on taken branches. It generalises the fixed 3-source/3-stage hazard unit to N sources, M producer stages, a configurable load-use distance and a multi-cycle branch flush. It adds a stall/flush state machine and saturating performance counters.

---
 rtl/hazard_forward_ctrl.sv | 146 ++++++++++++++
 tb/tb_hazard_forward_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/hazard_forward_ctrl.sv
// Hazard detection and operand forwarding controller for the pipelined datapath.
// Forward selects and stall/flush controls are combinational; the stall/flush
// sequencer state, remaining-cycle count and performance counters are registered.
module hazard_forward_ctrl #(
    parameter int unsigned NUM_SRC      = 3,
    parameter int unsigned NUM_STG      = 3,
    parameter int unsigned ADDR_W       = 4,
    parameter int unsigned LOAD_USE_STG = 1,
    parameter int unsigned BR_FLUSH     = 1,
    parameter int unsigned CNT_W        = 16,
    localparam int unsigned SEL_W       = $clog2(NUM_STG + 1)
) (
    input  logic                       clk_i,
    input  logic                       clr_i,
    input  logic [NUM_SRC*ADDR_W-1:0]  id_src_addr_i,
    input  logic [NUM_SRC-1:0]         id_src_used_i,
    input  logic [NUM_STG*ADDR_W-1:0]  stg_dst_addr_i,
    input  logic [NUM_STG-1:0]         stg_rf_en_i,
    input  logic [NUM_STG-1:0]         stg_is_load_i,
    input  logic                       branch_taken_i,
    output logic [NUM_SRC*SEL_W-1:0]   fwd_sel_o,
    output logic                       pc_en_o,
    output logic                       ifid_le_o,
    output logic                       nop_insert_o,
    output logic                       ifid_flush_o,
    output logic [1:0]                 fsm_state_o,
    output logic [CNT_W-1:0]           stall_cnt_o,
    output logic [CNT_W-1:0]           flush_cnt_o
);

    localparam int unsigned REM_MAX = (LOAD_USE_STG > BR_FLUSH) ? LOAD_USE_STG : BR_FLUSH;
    localparam int unsigned REM_W   = $clog2(REM_MAX + 1);
    localparam logic [ADDR_W-1:0] PC_REG = ADDR_W'(15);

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_STALL = 2'b01,
        ST_FLUSH = 2'b10
    } state_e;

    state_e             state_q, state_d;
    logic [REM_W-1:0]   rem_q, rem_d;
    logic [CNT_W-1:0]   stall_cnt_q, flush_cnt_q;

    logic [SEL_W-1:0]   sel_c;
    logic               hazard_c;
    int                 near_ld_c;
    int                 wait_c;

    // Nearest-stage forwarding per source and load-use hazard detection.
    always_comb begin
        fwd_sel_o = '0;
        hazard_c  = 1'b0;
        near_ld_c = int'(NUM_STG);
        sel_c     = '0;
        for (int i = 0; i < int'(NUM_SRC); i++) begin
            sel_c = '0;
            for (int k = int'(NUM_STG) - 1; k >= 0; k--) begin
                if (id_src_used_i[i] && stg_rf_en_i[k] &&
                    (stg_dst_addr_i[k*ADDR_W +: ADDR_W] == id_src_addr_i[i*ADDR_W +: ADDR_W]) &&
                    (id_src_addr_i[i*ADDR_W +: ADDR_W] != PC_REG)) begin
                    sel_c = SEL_W'(k + 1);
                    if (stg_is_load_i[k] && (k < int'(LOAD_USE_STG))) begin
                        hazard_c = 1'b1;
                        if (k < near_ld_c) near_ld_c = k;
                    end
                end
            end
            if (!clr_i) fwd_sel_o[i*SEL_W +: SEL_W] = sel_c;
        end
        wait_c = int'(LOAD_USE_STG) - near_ld_c;
    end

    // Stall/flush sequencer: next state, remaining count and pipeline controls.
    always_comb begin
        state_d      = state_q;
        rem_d        = rem_q;
        pc_en_o      = 1'b1;
        ifid_le_o    = 1'b1;
        nop_insert_o = 1'b0;
        ifid_flush_o = 1'b0;
        if (!clr_i) begin
            if (branch_taken_i) begin
                // A taken branch overrides any stall and (re)starts the flush window.
                ifid_flush_o = 1'b1;
                if (BR_FLUSH > 1) begin
                    rem_d   = REM_W'(BR_FLUSH - 1);
                    state_d = ST_FLUSH;
                end else begin
                    rem_d   = '0;
                    state_d = ST_RUN;
                end
            end else begin
                case (state_q)
                    ST_RUN: begin
                        if (hazard_c) begin
                            pc_en_o      = 1'b0;
                            ifid_le_o    = 1'b0;
                            nop_insert_o = 1'b1;
                            if (wait_c > 1) begin
                                rem_d   = REM_W'(wait_c - 1);
                                state_d = ST_STALL;
                            end
                        end
                    end
                    ST_STALL: begin
                        pc_en_o      = 1'b0;
                        ifid_le_o    = 1'b0;
                        nop_insert_o = 1'b1;
                        if (rem_q == REM_W'(1)) state_d = ST_RUN;
                        else                    rem_d   = rem_q - REM_W'(1);
                    end
                    ST_FLUSH: begin
                        ifid_flush_o = 1'b1;
                        if (rem_q == REM_W'(1)) state_d = ST_RUN;
                        else                    rem_d   = rem_q - REM_W'(1);
                    end
                    default: begin
                        state_d = ST_RUN;
                        rem_d   = '0;
                    end
                endcase
            end
        end
    end

    // State, remaining count and saturating event counters.
    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            state_q     <= ST_RUN;
            rem_q       <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            if (nop_insert_o && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            if (ifid_flush_o && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
        end
    end

    assign fsm_state_o = state_q;
    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Directed bench for hazard_forward_ctrl: three instances share the stimulus
// (A defaults, B LOAD_USE_STG=2/BR_FLUSH=2, C CNT_W=4); each section checks one.
module tb_hazard_forward_ctrl;

    logic        clk = 1'b0;
    logic        clr;
    logic [11:0] src_addr;
    logic [2:0]  src_used;
    logic [11:0] dst_addr;
    logic [2:0]  rf_en;
    logic [2:0]  is_load;
    logic        br;

    logic [5:0]  a_fwd, b_fwd, c_fwd;
    logic        a_pc, a_le, a_nop, a_fl;
    logic        b_pc, b_le, b_nop, b_fl;
    logic        c_pc, c_le, c_nop, c_fl;
    logic [1:0]  a_st, b_st, c_st;
    logic [15:0] a_sc, a_fc, b_sc, b_fc;
    logic [3:0]  c_sc, c_fc;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hazard_forward_ctrl u_a (
        .clk_i(clk), .clr_i(clr), .id_src_addr_i(src_addr), .id_src_used_i(src_used),
        .stg_dst_addr_i(dst_addr), .stg_rf_en_i(rf_en), .stg_is_load_i(is_load),
        .branch_taken_i(br), .fwd_sel_o(a_fwd), .pc_en_o(a_pc), .ifid_le_o(a_le),
        .nop_insert_o(a_nop), .ifid_flush_o(a_fl), .fsm_state_o(a_st),
        .stall_cnt_o(a_sc), .flush_cnt_o(a_fc)
    );

    hazard_forward_ctrl #(.LOAD_USE_STG(2), .BR_FLUSH(2)) u_b (
        .clk_i(clk), .clr_i(clr), .id_src_addr_i(src_addr), .id_src_used_i(src_used),
        .stg_dst_addr_i(dst_addr), .stg_rf_en_i(rf_en), .stg_is_load_i(is_load),
        .branch_taken_i(br), .fwd_sel_o(b_fwd), .pc_en_o(b_pc), .ifid_le_o(b_le),
        .nop_insert_o(b_nop), .ifid_flush_o(b_fl), .fsm_state_o(b_st),
        .stall_cnt_o(b_sc), .flush_cnt_o(b_fc)
    );

    hazard_forward_ctrl #(.CNT_W(4)) u_c (
        .clk_i(clk), .clr_i(clr), .id_src_addr_i(src_addr), .id_src_used_i(src_used),
        .stg_dst_addr_i(dst_addr), .stg_rf_en_i(rf_en), .stg_is_load_i(is_load),
        .branch_taken_i(br), .fwd_sel_o(c_fwd), .pc_en_o(c_pc), .ifid_le_o(c_le),
        .nop_insert_o(c_nop), .ifid_flush_o(c_fl), .fsm_state_o(c_st),
        .stall_cnt_o(c_sc), .flush_cnt_o(c_fc)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [3:0] s0, input logic [3:0] s1, input logic [3:0] s2,
                         input logic [2:0] used,
                         input logic [3:0] d0, input logic [3:0] d1, input logic [3:0] d2,
                         input logic [2:0] rf, input logic [2:0] ld, input logic b);
        src_addr = {s2, s1, s0};
        src_used = used;
        dst_addr = {d2, d1, d0};
        rf_en    = rf;
        is_load  = ld;
        br       = b;
        #1;
    endtask

    task automatic idle();
        drive(4'd0, 4'd0, 4'd0, 3'b000, 4'd0, 4'd0, 4'd0, 3'b000, 3'b000, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_pulse();
        clr = 1'b1;
        idle();
        tick();
        clr = 1'b0;
    endtask

    initial begin
        clr = 1'b1;
        // Reset: a live load-use match must be masked while CLR is high.
        drive(4'd3, 4'd0, 4'd0, 3'b001, 4'd3, 4'd0, 4'd0, 3'b001, 3'b001, 1'b0);
        tick();
        check("rst_fwd", a_fwd, 0);
        check("rst_pc", a_pc, 1);
        check("rst_nop", a_nop, 0);
        tick();
        check("rst_state", a_st, 0);
        check("rst_scnt", a_sc, 0);
        clr = 1'b0;

        // Priority: EX and MEM both write R3 -> EX wins; EX disabled -> MEM.
        drive(4'd3, 4'd0, 4'd0, 3'b001, 4'd3, 4'd3, 4'd0, 3'b011, 3'b000, 1'b0);
        check("prio_ex", a_fwd, 6'h01);
        check("prio_pc", a_pc, 1);
        drive(4'd3, 4'd0, 4'd0, 3'b001, 4'd3, 4'd3, 4'd0, 3'b010, 3'b000, 1'b0);
        check("prio_mem", a_fwd, 6'h02);
        // Source 2 reads WB-only register.
        drive(4'd0, 4'd0, 4'd7, 3'b100, 4'd0, 4'd0, 4'd7, 3'b100, 3'b000, 1'b0);
        check("src2_wb", a_fwd, 6'h30);
        tick();

        // Load-use with defaults: one stall cycle, then MEM forward.
        drive(4'd0, 4'd2, 4'd0, 3'b010, 4'd2, 4'd0, 4'd0, 3'b001, 3'b001, 1'b0);
        check("lu_pc", a_pc, 0);
        check("lu_le", a_le, 0);
        check("lu_nop", a_nop, 1);
        check("lu_state", a_st, 0);
        tick();
        drive(4'd0, 4'd2, 4'd0, 3'b010, 4'd0, 4'd2, 4'd0, 3'b010, 3'b010, 1'b0);
        check("lu_fwd", a_fwd, 6'h08);
        check("lu_pc2", a_pc, 1);
        check("lu_scnt", a_sc, 1);
        check("lu_state2", a_st, 0);

        // LOAD_USE_STG=2: two stall cycles then WB forward.
        clr_pulse();
        drive(4'd4, 4'd0, 4'd0, 3'b001, 4'd4, 4'd0, 4'd0, 3'b001, 3'b001, 1'b0);
        check("lu2_pc0", b_pc, 0);
        check("lu2_st0", b_st, 0);
        tick();
        drive(4'd4, 4'd0, 4'd0, 3'b001, 4'd0, 4'd4, 4'd0, 3'b010, 3'b010, 1'b0);
        check("lu2_st1", b_st, 1);
        check("lu2_pc1", b_pc, 0);
        check("lu2_nop1", b_nop, 1);
        tick();
        drive(4'd4, 4'd0, 4'd0, 3'b001, 4'd0, 4'd0, 4'd4, 3'b100, 3'b100, 1'b0);
        check("lu2_st2", b_st, 0);
        check("lu2_fwd", b_fwd, 6'h03);
        check("lu2_pc2", b_pc, 1);
        check("lu2_scnt", b_sc, 2);

        // R15 never forwarded; unused source never matches or stalls.
        drive(4'd15, 4'd0, 4'd0, 3'b001, 4'd15, 4'd0, 4'd0, 3'b001, 3'b001, 1'b0);
        check("r15_fwd", a_fwd, 0);
        check("r15_nop", a_nop, 0);
        drive(4'd5, 4'd0, 4'd0, 3'b000, 4'd5, 4'd0, 4'd0, 3'b001, 3'b001, 1'b0);
        check("unused_fwd", a_fwd, 0);
        check("unused_pc", a_pc, 1);
        tick();

        // Branch during second stall cycle (B); single-cycle flush on A.
        clr_pulse();
        drive(4'd4, 4'd0, 4'd0, 3'b001, 4'd4, 4'd0, 4'd0, 3'b001, 3'b001, 1'b0);
        check("bs_nop0", b_nop, 1);
        tick();
        drive(4'd4, 4'd0, 4'd0, 3'b001, 4'd0, 4'd4, 4'd0, 3'b010, 3'b010, 1'b1);
        check("bs_st1", b_st, 1);
        check("bs_nop1", b_nop, 0);
        check("bs_fl1", b_fl, 1);
        check("bs_pc1", b_pc, 1);
        check("bs_a_fl", a_fl, 1);
        tick();
        idle();
        check("bs_st2", b_st, 2);
        check("bs_fl2", b_fl, 1);
        check("bs_pc2", b_pc, 1);
        check("bs_a_fl2", a_fl, 0);
        check("bs_a_st2", a_st, 0);
        tick();
        check("bs_st3", b_st, 0);
        check("bs_fl3", b_fl, 0);
        check("bs_fcnt", b_fc, 2);
        check("bs_scnt", b_sc, 1);
        check("bs_a_fcnt", a_fc, 1);

        // Counter saturation on C; B alternates RUN/STALL under the same hazard.
        clr_pulse();
        drive(4'd0, 4'd2, 4'd0, 3'b010, 4'd2, 4'd0, 4'd0, 3'b001, 3'b001, 1'b0);
        for (int n = 1; n <= 21; n++) begin
            tick();
            if (n == 14) check("sat_14", c_sc, 14);
            if (n == 15) check("sat_15", c_sc, 15);
            if (n == 20) check("sat_20", c_sc, 15);
        end
        check("mid_st", b_st, 1);
        check("mid_bscnt", b_sc, 21);
        clr = 1'b1;
        #1;
        check("clr_pc", b_pc, 1);
        check("clr_nop", b_nop, 0);
        check("clr_fwd", b_fwd, 0);
        tick();
        clr = 1'b0;
        idle();
        check("post_st", b_st, 0);
        check("post_bscnt", b_sc, 0);
        check("post_cscnt", c_sc, 0);
        check("post_pc", b_pc, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
